regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised general-purpose register file for the single-cycle core: two read ports, one write port.
//   Takes explicit register addresses; field decode moves to the decoder.
//   Adds clocked writes, registered reads, async reset, optional hard-zero entry 0 and a cycle-by-cycle sweep-clear engine.
//   Sits between the decoder (addresses) and the ALU / writeback mux (data).
// PARAMETERS
//   DATA_W    16  width of each register in bits
//   DEPTH     16  number of registers (power of two, >= 2)
//   ADDR_W    4   address width, must equal log2(DEPTH)
//   ZERO_REG  0   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//   clk       in   1       core clock, rising edge
//   rst       in   1       asynchronous, active-high reset
//   we        in   1       write enable, sampled on clk
//   waddr     in   ADDR_W  write address
//   wdata     in   DATA_W  write data
//   raddr1    in   ADDR_W  read port 1 address (ALU operand A)
//   raddr2    in   ADDR_W  read port 2 address (ALU operand B)
//   rdata1    out  DATA_W  registered read data, port 1
//   rdata2    out  DATA_W  registered read data, port 2
//   clr_req   in   1       single-cycle pulse; starts a sweep-clear
//   clr_busy  out  1       high while the sweep is running
//   clr_done  out  1       one-cycle pulse on the last sweep cycle
// BEHAVIOUR
//   Reset: rst=1 asynchronously clears all entries, rdata1/2, clr_busy and clr_done to 0. FSM enters IDLE and the sweep pointer goes to 0.
//   Write: if we && !clr_busy, RegFile[waddr] <= wdata at the rising edge. A write to entry 0 is dropped when ZERO_REG=1.
//   Read latency: 1 cycle. rdataN <= RegFile[raddrN] at the edge, or 0 if ZERO_REG=1 and raddrN==0.
//   Read during clr_busy: rdata1/2 are forced to 0.
//   Same-address read/write in one cycle: behaviour depends on REGFILE_BYPASS_EN (see CONFIGURATION).
//   Two ports reading the same address must return identical data.
//   FSM IDLE: on clr_req, go to SWEEP. clr_busy=1 from the next cycle. ptr=0.
//   FSM SWEEP: each cycle RegFile[ptr] <= 0 and ptr <= ptr+1.
//     When ptr==DEPTH-1, that entry is cleared, clr_done pulses in the same cycle, and the FSM goes to IDLE.
//     clr_busy is high for exactly DEPTH cycles.
//   clr_req while SWEEP: ignored; no restart.
//   we while clr_busy: dropped silently. The caller must stall.
//   Same-cycle clr_req and we in IDLE: the write commits, then the sweep clears it.
//   rst mid-sweep: immediate abort. All entries are 0 anyway, and the FSM returns to IDLE.
//   ptr wraps only through the FSM exit; it never exceeds DEPTH-1.
// CONFIGURATION
//   Macro REGFILE_BYPASS_EN.
//   Defined: write-first forwarding. If we && !clr_busy && waddr==raddrN (and not the zero entry when ZERO_REG=1), rdataN <= wdata in the same edge.
//   Undefined: read-first. rdataN gets the old contents; the new value is visible one cycle later.
// STRUCTURE
//   Shared package regfile_pkg: constants RF_DATA_W=16, RF_DEPTH=16, RF_ADDR_W=4.
//   The package also holds typedef rf_clr_state_t {RF_IDLE, RF_SWEEP}, used by the decoder and the bench.
//   One natural sub-module, regfile_read_port: a single registered read with bypass/zero logic, instantiated twice.
//   The storage array and the clear FSM stay in the top module.
// TESTING
//   1. rst pulse mid-cycle (async), then read all 16 addresses -> every rdata is 0x0000, clr_busy=0.
//   2. Write 0xBEEF to r5, read r5 on both ports next cycle -> rdata1=rdata2=0xBEEF one cycle after the read address is applied.
//   3. Same-cycle write 0x1234 to r3 and read r3:
//      -> 0x1234 with REGFILE_BYPASS_EN; old value 0x0000 without it, then 0x1234 the following cycle.
//   4. ZERO_REG=1: write 0xFFFF to r0, read r0 -> 0x0000; r1 unaffected.
//   5. Fill r0..r15 with 0xA000+i, pulse clr_req:
//      -> clr_busy high exactly 16 cycles, clr_done single pulse on the 16th.
//      -> we asserted mid-sweep is dropped; all reads return 0 afterwards.
//   6. Assert rst at sweep cycle 7 -> clr_busy falls asynchronously, FSM IDLE.
//      -> a new clr_req then runs a full 16-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 2-read / 1-write register file.
//   RF_DATA_W / RF_DEPTH / RF_ADDR_W : default geometry (16 x 16-bit)
//   rf_clr_state_t                   : sweep-clear engine states, also used
//                                      by the decoder and the testbench
// Optional feature macro used by the register file: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_DEPTH  = 16;
   localparam int RF_ADDR_W = 4;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_clr_state_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// -----------------------------------------------------------------------------
// regfile_2r1w_if
// Bundles the register-file access signals.
//   we, waddr, wdata      : write port (driven by master)
//   raddr1, raddr2        : read addresses (driven by master)
//   rdata1, rdata2        : registered read data (driven by slave)
//   clr_req               : sweep-clear start pulse (driven by master)
//   clr_busy, clr_done    : sweep status (driven by slave)
// Modports: master = core side, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_2r1w_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
);

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;

   modport master (
      output we, waddr, wdata, raddr1, raddr2, clr_req,
      input  rdata1, rdata2, clr_busy, clr_done
   );

   modport slave (
      input  we, waddr, wdata, raddr1, raddr2, clr_req,
      output rdata1, rdata2, clr_busy, clr_done
   );

endinterface

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file (1-cycle latency).
//   clk, rst   : clock, asynchronous active-high reset
//   clr_busy   : sweep in progress; read data is forced to zero
//   raddr      : read address
//   entry      : current storage contents at raddr (muxed by the parent)
//   we, waddr, wdata : write port, used only for write-first forwarding
//   rdata      : registered read data
// Parameters: DATA_W, ADDR_W, ZERO_REG (1 = entry 0 reads as zero).
// Macro REGFILE_BYPASS_EN: defined -> write-first forwarding of a same-cycle
// write to the same address; undefined -> read-first (old contents).
// -----------------------------------------------------------------------------
module regfile_read_port #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_busy,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0] entry,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] next_data;
   logic              zero_hit;

   // A hard-zero entry never forwards, so it is checked before the bypass.
   assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

`ifdef REGFILE_BYPASS_EN
   // Write-first: a write landing on the address being read this cycle is
   // returned directly instead of the stale array contents.
   always_comb begin
      next_data = entry;
      if (clr_busy || zero_hit) begin
         next_data = '0;
      end else if (we && (waddr == raddr)) begin
         next_data = wdata;
      end
   end
`else
   // Read-first: the array contents before this edge's write are returned.
   // The write-side inputs only matter for forwarding.
   logic unused_write_side;
   assign unused_write_side = ^{we, waddr, wdata};

   always_comb begin
      next_data = entry;
      if (clr_busy || zero_hit) begin
         next_data = '0;
      end
   end
`endif

   // Output register giving the one-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= next_data;
      end
   end

endmodule

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// General-purpose register file: two registered read ports, one clocked write
// port, optional hard-zero entry 0 and a one-entry-per-cycle sweep-clear.
//   clk  : core clock, rising edge
//   rst  : asynchronous, active-high reset (clears all state)
//   bus  : regfile_2r1w_if.slave (write port, read ports, clear handshake)
// Parameters: DATA_W, DEPTH (power of two), ADDR_W = log2(DEPTH), ZERO_REG.
// Macro REGFILE_BYPASS_EN selects write-first forwarding on same-address
// read/write (see regfile_read_port); undefined gives read-first behaviour.
// -----------------------------------------------------------------------------
module regfile_2r1w
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 0
) (
   input  logic            clk,
   input  logic            rst,
   regfile_2r1w_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   rf_clr_state_t     state_q;
   rf_clr_state_t     state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   logic              clr_busy;
   logic              write_ok;

   // Busy is a direct decode of the state register so that reset drops it
   // asynchronously; done marks the cycle that clears the last entry.
   assign clr_busy     = (state_q == RF_SWEEP);
   assign bus.clr_busy = clr_busy;
   assign bus.clr_done = clr_busy && (ptr_q == LAST_ENTRY);

   // Writes are blocked during a sweep, and entry 0 is read-only when it is
   // hard-wired to zero.
   assign write_ok = bus.we && !clr_busy &&
                     !((ZERO_REG != 0) && (bus.waddr == '0));

   // Sweep-clear state and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Sweep-clear next state: one entry per cycle, leaving after the last one.
   // The pointer wraps back to zero on that same exit edge; a clr_req seen
   // while sweeping is ignored.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         RF_IDLE: begin
            if (bus.clr_req) begin
               state_d = RF_SWEEP;
               ptr_d   = '0;
            end
         end
         RF_SWEEP: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_ENTRY) begin
               state_d = RF_IDLE;
            end
         end
         default: begin
            state_d = RF_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Storage array. The sweep owns the array while busy; otherwise the write
   // port updates it. A write in the same cycle as clr_req still commits
   // because the sweep only starts on the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr_busy) begin
         mem[ptr_q] <= '0;
      end else if (write_ok) begin
         mem[bus.waddr] <= bus.wdata;
      end
   end

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_read_port1 (
      .clk      (clk),
      .rst      (rst),
      .clr_busy (clr_busy),
      .raddr    (bus.raddr1),
      .entry    (mem[bus.raddr1]),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (bus.rdata1)
   );

   regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_read_port2 (
      .clk      (clk),
      .rst      (rst),
      .clr_busy (clr_busy),
      .raddr    (bus.raddr2),
      .entry    (mem[bus.raddr2]),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (bus.rdata2)
   );

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
// Self-checking bench for regfile_2r1w. Two instances share one stimulus
// stream: dut (ZERO_REG=0) and dut_z (ZERO_REG=1). Expected values come from
// a per-instance array model plus a remaining-sweep-cycles counter, and are
// queued when a step is driven and compared one edge later.
// Honours REGFILE_BYPASS_EN for the same-address read/write expectation.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;
   import regfile_pkg::*;

   typedef struct {
      string       tag;
      logic [15:0] r1;
      logic [15:0] r2;
      logic [15:0] z1;
      logic [15:0] z2;
      logic        busy;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks = 0;
   int errors = 0;

   exp_t          sb [$];
   logic [15:0]   mdl   [16];
   logic [15:0]   mdl_z [16];
   int            sweep_left = 0;
   rf_clr_state_t exp_state  = RF_IDLE;

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   regfile_2r1w_if #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) bm ();
   regfile_2r1w_if #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W)) bz ();

   // The zero-entry instance mirrors every input of the main instance.
   assign bz.we      = bm.we;
   assign bz.waddr   = bm.waddr;
   assign bz.wdata   = bm.wdata;
   assign bz.raddr1  = bm.raddr1;
   assign bz.raddr2  = bm.raddr2;
   assign bz.clr_req = bm.clr_req;

   regfile_2r1w #(
      .DATA_W   (RF_DATA_W),
      .DEPTH    (RF_DEPTH),
      .ADDR_W   (RF_ADDR_W),
      .ZERO_REG (0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bm)
   );

   regfile_2r1w #(
      .DATA_W   (RF_DATA_W),
      .DEPTH    (RF_DEPTH),
      .ADDR_W   (RF_ADDR_W),
      .ZERO_REG (1)
   ) dut_z (
      .clk (clk),
      .rst (rst),
      .bus (bz)
   );

   task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h, expected %h", name, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] expect_read(input logic [3:0] a, input logic w,
                                               input logic [3:0] wa, input logic [15:0] wd,
                                               input logic busy, input bit zero);
      if (busy) return 16'h0000;
      if (zero && a == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
      if (w && wa == a) return wd;
`endif
      return zero ? mdl_z[a] : mdl[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mdl[i]   = 16'h0000;
         mdl_z[i] = 16'h0000;
      end
      sweep_left = 0;
      exp_state  = RF_IDLE;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".rdata1"},   bm.rdata1, e.r1);
      chk({e.tag, ".rdata2"},   bm.rdata2, e.r2);
      chk({e.tag, ".z_rdata1"}, bz.rdata1, e.z1);
      chk({e.tag, ".z_rdata2"}, bz.rdata2, e.z2);
      chk({e.tag, ".clr_busy"}, {15'd0, bm.clr_busy}, {15'd0, e.busy});
      chk({e.tag, ".clr_done"}, {15'd0, bm.clr_done}, {15'd0, e.done});
      chk({e.tag, ".z_clr_busy"}, {15'd0, bz.clr_busy}, {15'd0, e.busy});
   endtask

   // Drive one cycle of inputs (called just after a rising edge), queue the
   // expectation, let the edge happen, then compare.
   task automatic applyStimulus(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                                input logic [3:0] a1, input logic [3:0] a2,
                                input logic clr, input string tag);
      exp_t e;
      logic busy_pre;
      bm.we      = w;
      bm.waddr   = wa;
      bm.wdata   = wd;
      bm.raddr1  = a1;
      bm.raddr2  = a2;
      bm.clr_req = clr;
      busy_pre   = (sweep_left > 0);
      e.tag = tag;
      e.r1  = expect_read(a1, w, wa, wd, busy_pre, 1'b0);
      e.r2  = expect_read(a2, w, wa, wd, busy_pre, 1'b0);
      e.z1  = expect_read(a1, w, wa, wd, busy_pre, 1'b1);
      e.z2  = expect_read(a2, w, wa, wd, busy_pre, 1'b1);
      if (busy_pre) begin
         mdl[16 - sweep_left]   = 16'h0000;
         mdl_z[16 - sweep_left] = 16'h0000;
         sweep_left--;
      end else begin
         if (w) begin
            mdl[wa] = wd;
            if (wa != 4'd0) mdl_z[wa] = wd;
         end
         if (clr) sweep_left = 16;
      end
      exp_state = (sweep_left > 0) ? RF_SWEEP : RF_IDLE;
      e.busy = (exp_state == RF_SWEEP);
      e.done = (sweep_left == 1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      bm.we      = 1'b0;
      bm.clr_req = 1'b0;
      checkOutput();
   endtask

   // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, ".async_busy"},  {15'd0, bm.clr_busy}, 16'h0000);
      chk({tag, ".async_done"},  {15'd0, bm.clr_done}, 16'h0000);
      chk({tag, ".async_rd1"},   bm.rdata1, 16'h0000);
      chk({tag, ".async_rd2"},   bm.rdata2, 16'h0000);
      chk({tag, ".async_zbusy"}, {15'd0, bz.clr_busy}, 16'h0000);
      #2 rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bm.we      = 1'b0;
      bm.waddr   = '0;
      bm.wdata   = '0;
      bm.raddr1  = '0;
      bm.raddr2  = '0;
      bm.clr_req = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      $display("[TB] reset and read-back of all entries");
      pulse_reset("reset");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0, $sformatf("rd_reset%0d", i));
      end

      $display("[TB] write then read on both ports");
      applyStimulus(1'b1, 4'd5, 16'hBEEF, 4'd0, 4'd1, 1'b0, "wr_r5");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd5, 4'd5, 1'b0, "rd_r5");

      $display("[TB] same-cycle read and write");
      applyStimulus(1'b1, 4'd3, 16'h1234, 4'd3, 4'd3, 1'b0, "rw_r3");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd3, 4'd3, 1'b0, "rd_r3");
      applyStimulus(1'b1, 4'd7, 16'h5A5A, 4'd5, 4'd3, 1'b0, "wr_r7");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd7, 4'd5, 1'b0, "rd_r7");

      $display("[TB] entry 0 behaviour");
      applyStimulus(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd1, 1'b0, "wr_r0");
      applyStimulus(1'b1, 4'd1, 16'h0101, 4'd0, 4'd1, 1'b0, "wr_r1");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd0, 4'd1, 1'b0, "rd_r0r1");

      $display("[TB] fill and sweep-clear");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'(i), 16'hA000 + 16'(i), 4'(i), 4'((i + 1) % 16), 1'b0,
                       $sformatf("fill%0d", i));
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 4'd15, 4'd0, 1'b0, "rd_fill");
      applyStimulus(1'b1, 4'd9, 16'h9999, 4'd9, 4'd10, 1'b1, "clr_start");
      for (int i = 0; i < 16; i++) begin
         applyStimulus((i == 8), 4'd2, 16'h7777, 4'(i), 4'd2, (i == 5),
                       $sformatf("sweep%0d", i));
      end
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0, $sformatf("rd_swept%0d", i));
      end

      $display("[TB] reset in the middle of a sweep");
      applyStimulus(1'b1, 4'd4, 16'h4444, 4'd0, 4'd0, 1'b0, "wr_r4");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd4, 4'd4, 1'b1, "clr_again");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 4'd4, 4'd6, 1'b0, $sformatf("part_sweep%0d", i));
      end
      pulse_reset("mid_sweep_reset");
      applyStimulus(1'b1, 4'd6, 16'h6666, 4'd6, 4'd0, 1'b0, "wr_r6");
      applyStimulus(1'b0, 4'd0, 16'h0,    4'd6, 4'd6, 1'b1, "clr_full");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 4'd6, 4'(i), 1'b0, $sformatf("full_sweep%0d", i));
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 4'd6, 4'd5, 1'b0, "rd_after_full");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so a stuck run still ends with a summary.
   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL timeout: observed no completion, expected finish before 200000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule
